// File: rtl/mult_seq_if.sv
// mult_seq_if: request/response bundle between the EX-stage caller and the iterative multiplier
interface mult_seq_if #(
    parameter int WIDTH = 32
);
    logic                   signed_mul_i;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;
    modport master (
        output signed_mul_i, a, b, start_i, annul_i,
        input  result_o, ready_o
    );
    modport slave (
        input  signed_mul_i, a, b, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: fixed-latency shift-add multiplier for MULT/MULTU with start/annul/ready handshake
module mult_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    mult_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mag_a_q, mag_b_q;
    logic [WIDTH-1:0]     mag_a_d, mag_b_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 accept, step, last;
    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // Next state: annul always falls back to IDLE; BUSY runs a fixed WIDTH cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (bus.start_i && !bus.annul_i) ? BUSY : IDLE;
            BUSY:    state_d = bus.annul_i ? IDLE : (last ? DONE : BUSY);
            default: state_d = IDLE;
        endcase
    end
    // Control outputs; ready is a Moore output so an annul in DONE still shows the pulse
    always_comb begin
        accept      = (state_q == IDLE) && bus.start_i && !bus.annul_i;
        step        = (state_q == BUSY) && !bus.annul_i;
        last        = step && (cnt_q == CNT_W'(WIDTH - 1));
        bus.ready_o = (state_q == DONE);
    end
    // Datapath next values: operand magnitudes at accept, one partial product per BUSY cycle
    always_comb begin
        mag_a_d  = (bus.signed_mul_i && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b_d  = (bus.signed_mul_i && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        neg_d    = bus.signed_mul_i && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        acc_d    = acc_q + (mag_b_q[0] ? ({{WIDTH{1'b0}}, mag_a_q} << cnt_q) : '0);
        result_d = neg_q ? -acc_d : acc_d;
    end
    // Datapath registers; the product is committed on the final BUSY edge so it is valid in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step) begin
            acc_q    <= acc_d;
            mag_b_q  <= mag_b_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last) result_q <= result_d;
        end
    end
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed scoreboard bench for mult_seq
module tb_mult_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mult_seq_if #(.WIDTH(32)) bus();
    mult_seq #(.WIDTH(32), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [63:0] exp_q[$];
    logic [63:0] last_res = '0;
    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Monitor: every ready pulse pops one expected product
    always @(negedge clk) begin
        if (!rst && bus.ready_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got result %h with nothing outstanding", bus.result_o);
            end else begin
                chk("result", bus.result_o, exp_q.pop_front());
            end
        end
    end
    task automatic op(input logic sm, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] e, input bit mid);
        int n;
        @(posedge clk); #1;
        bus.signed_mul_i = sm; bus.a = a; bus.b = b; bus.start_i = 1'b1;
        exp_q.push_back(e);
        last_res = e;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus.ready_o) break;
            if (mid && n == 5) begin
                bus.a = ~a; bus.b = a ^ b; bus.signed_mul_i = ~sm; bus.start_i = 1'b1;
            end
            if (mid && n == 7) bus.start_i = 1'b0;
        end
        chk("latency", 64'(n), 64'd33);
        @(negedge clk);
        chk("ready_pulse_width", 64'(bus.ready_o), 64'd0);
    endtask
    task automatic no_ready(input string name);
        int seen;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o) seen++;
        end
        chk(name, 64'(seen), 64'd0);
    endtask
    initial begin
        bus.signed_mul_i = 1'b0; bus.a = '0; bus.b = '0; bus.start_i = 1'b0; bus.annul_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", bus.result_o, 64'd0);
        chk("reset_ready", 64'(bus.ready_o), 64'd0);
        rst = 1'b0;
        op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
        op(1'b1, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0);
        op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0);
        op(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
        op(1'b1, 32'h80000000, 32'd0,        64'h00000000_00000000, 1'b0);
        op(1'b0, 32'h80000000, 32'd2,        64'h00000001_00000000, 1'b0);
        op(1'b1, 32'd7,        32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFF2, 1'b0);
        // annul at BUSY cycle 10
        @(posedge clk); #1;
        bus.signed_mul_i = 1'b0; bus.a = 32'd7; bus.b = 32'd9; bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        no_ready("annul_no_ready");
        chk("annul_result_hold", bus.result_o, last_res);
        op(1'b0, 32'd7, 32'd9, 64'h3F, 1'b0);
        // reset at BUSY cycle 20
        @(posedge clk); #1;
        bus.signed_mul_i = 1'b0; bus.a = 32'd123; bus.b = 32'd456; bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_ready", 64'(bus.ready_o), 64'd0);
        chk("midreset_result", bus.result_o, 64'd0);
        no_ready("midreset_no_ready");
        op(1'b1, 32'hFFFFFFF9, 32'd6, 64'hFFFFFFFF_FFFFFFD6, 1'b0);
        // operand changes and start pulses during BUSY are ignored
        op(1'b1, 32'd6, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFE8, 1'b1);
        // start and annul together in IDLE: nothing accepted
        @(posedge clk); #1;
        bus.a = 32'd3; bus.b = 32'd3; bus.start_i = 1'b1; bus.annul_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0; bus.annul_i = 1'b0;
        no_ready("idle_annul_wins");
        op(1'b0, 32'd12345, 32'd1000, 64'd12345000, 1'b0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
Iterative shift-add multiplier for MULT/MULTU, placed in the EX stage beside the ALU. It feeds the ALU's 64-bit ans path, as the divider does, and uses the same start/annul/ready handshake. This lets the single-cycle `*` be removed from the ALU's combinational path. The caller holds start_i high while ready_o is low and stalls the pipeline for that time.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits.
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
signed_mul_i  in  1  1 = MULT (two's complement), 0 = MULTU.
a  in  WIDTH  multiplicand (rs).
b  in  WIDTH  multiplier (rt).
start_i  in  1  request; sampled only in IDLE.
annul_i  in  1  abort the current operation (exception or flush).
result_o  out  2*WIDTH  product; {hi, lo} = result_o[63:32], result_o[31:0].
ready_o  out  1  one-cycle pulse; result_o is valid in that cycle.

Behaviour:
- Reset: when rst is high at a clock edge:
  - state = IDLE, ready_o = 0, result_o = 0, counter = 0, internal accumulators = 0.
  - Reset in any state, including mid-operation, aborts immediately with no ready pulse.
- States: IDLE, BUSY, DONE. The encoding is free.
- IDLE:
  - If start_i=1 and annul_i=0, accept the request:
    - latch mag_a = |a| and mag_b = |b| when signed_mul_i=1, otherwise raw a and b;
    - latch neg = signed_mul_i & (a[WIDTH-1] ^ b[WIDTH-1]);
    - clear the 64-bit accumulator; counter = 0; go to BUSY.
  - start_i and annul_i both high in IDLE: annul wins; nothing is accepted.
- BUSY (exactly WIDTH cycles):
  - each cycle, if mag_b[0] then acc += mag_a << counter (zero-extended to 64 bits);
  - mag_b >>= 1; counter += 1;
  - when counter == WIDTH-1 is processed, go to DONE.
- DONE (1 cycle):
  - result_o = neg ? -acc : acc (64-bit two's complement negate), registered;
  - ready_o = 1 during this cycle only; next state = IDLE unconditionally.
- Latency:
  - request accepted at edge E0;
  - BUSY occupies cycles 1..32;
  - ready_o is high in cycle 33 after acceptance, i.e. 34 cycles from the start_i sample to ready deassertion;
  - fixed, data-independent; no early termination.
- Arithmetic:
  - The magnitude of -2^31 is 0x80000000, which fits in 32 unsigned bits.
  - The maximum magnitude product is 2^62 (signed) or (2^32-1)^2 (unsigned); neither overflows 64 bits.
  - Signed ×0 gives +0, never -0.
- Annul:
  - annul_i=1 in BUSY or DONE returns to IDLE at the next edge.
  - ready_o is 0 in that next cycle; if annul_i occurs in DONE, the ready pulse in that same cycle still shows.
  - result_o keeps its previous value when annulled in BUSY.
- start_i in BUSY or DONE is ignored; operands are not re-latched.
- Changing a, b or signed_mul_i after acceptance has no effect on the result.
- result_o holds its value until the next DONE or reset.
- Back-to-back requests:
  - start_i high in the IDLE cycle right after DONE starts a new operation.
  - The caller deasserts start_i in the ready cycle.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> ready_o high exactly 33 cycles after the accept edge; result_o=0xFFFFFFFE_00000001; ready_o high for 1 cycle only.
- MULT a=0xFFFFFFFD (-3), b=5 -> 0xFFFFFFFF_FFFFFFF1. MULT a=-1, b=-1 -> 0x00000000_00000001. MULT a=b=0x80000000 -> 0x40000000_00000000.
- MULT a=0x80000000, b=0 -> result_o=0; MULTU 0x80000000×2 -> 0x00000001_00000000.
- Annul at BUSY cycle 10 of a=7, b=9 -> no ready pulse; result_o unchanged from the prior value. A following start with a=7, b=9 -> 63 (0x3F) after full latency.
- Assert rst at BUSY cycle 20 -> next cycle ready_o=0, result_o=0, state IDLE; a new request completes normally.
- Mid-operation: toggle a, b and pulse start_i in BUSY -> result equals the originally latched operands. In IDLE, start_i=annul_i=1 -> no BUSY entry.
